// File: rtl/sb_pkg.sv
// Shared constants, frame-FSM state type and CRC-16 helper for the sideband receive path.
package sb_pkg;

    localparam logic [7:0]  DLE = 8'hFE;
    localparam logic [7:0]  STX = 8'h05;
    localparam logic [7:0]  ETX = 8'h40;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        StHunt,
        StSof,
        StBody,
        StEsc
    } frame_state_e;

    // One byte of CRC-16, MSB first, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_sym_deser.sv
// 10-bit sideband symbol deserializer: start 0, 8 data bits LSB first, stop 1.
module sb_sym_deser (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sbrx,
    output logic [7:0] o_byte,
    output logic       o_strobe,
    output logic       o_sym_error,
    output logic       o_stop_fail
);

    typedef enum logic [2:0] {
        SdIdle,
        SdStart,
        SdData,
        SdStop,
        SdArm
    } deser_state_e;

    deser_state_e r_state;
    logic [7:0]   r_shift;
    logic [7:0]   r_byte;
    logic [2:0]   r_bit_cnt;
    logic         r_strobe;
    logic         r_sym_error;

    // Early (unregistered) view of a bad stop bit so the framer can flag the abort in the same
    // cycle as the registered sym_error.
    assign o_stop_fail = (r_state == SdStop) && !i_sbrx;
    assign o_byte      = r_byte;
    assign o_strobe    = r_strobe;
    assign o_sym_error = r_sym_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SdIdle;
            r_shift     <= '0;
            r_byte      <= '0;
            r_bit_cnt   <= '0;
            r_strobe    <= 1'b0;
            r_sym_error <= 1'b0;
        end else begin
            r_strobe    <= 1'b0;
            r_sym_error <= 1'b0;
            case (r_state)
                SdIdle: begin
                    if (!i_sbrx) r_state <= SdStart;
                end
                SdStart: begin
                    r_shift   <= {i_sbrx, r_shift[7:1]};
                    r_bit_cnt <= 3'd1;
                    r_state   <= SdData;
                end
                SdData: begin
                    r_shift   <= {i_sbrx, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= SdStop;
                end
                SdStop: begin
                    if (i_sbrx) begin
                        r_byte   <= r_shift;
                        r_strobe <= 1'b1;
                        r_state  <= SdIdle;
                    end else begin
                        r_sym_error <= 1'b1;
                        r_state     <= SdArm;
                    end
                end
                SdArm: begin
                    if (i_sbrx) r_state <= SdIdle;
                end
                default: r_state <= SdIdle;
            endcase
        end
    end

endmodule

// File: rtl/sb_rx_framer.sv
// Sideband receive framer: strips DLE/STX..DLE/ETX framing and DLE stuffing, buffers the payload
// and checks the CRC-16 residue, presenting one transaction per good frame.
module sb_rx_framer
    import sb_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 8,
    parameter int unsigned LW          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     i_sb_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sbrx,
    output logic [8*MAX_PAYLOAD-1:0] o_payload,
    output logic [LW-1:0]            o_payload_len,
    output logic                     o_crc_ok,
    output logic                     o_frame_valid,
    output logic                     o_frame_error,
    output logic                     o_sym_error
);

    // Buffer also holds the two trailing CRC bytes.
    localparam int unsigned BUF_BYTES = MAX_PAYLOAD + 2;
    localparam int unsigned CW        = $clog2(BUF_BYTES + 1);

    logic [7:0]    w_byte;
    logic          w_strobe;
    logic          w_stop_fail;
    logic          w_store;
    logic          w_full;

    frame_state_e  r_state;
    logic [15:0]   r_crc;
    logic [CW-1:0] r_count;
    logic [7:0]    r_buf [BUF_BYTES];

    sb_sym_deser u_deser (
        .i_clk       (i_sb_clk),
        .i_rst_n     (i_rst_n),
        .i_sbrx      (i_sbrx),
        .o_byte      (w_byte),
        .o_strobe    (w_strobe),
        .o_sym_error (o_sym_error),
        .o_stop_fail (w_stop_fail)
    );

    // A data byte is stored either directly in BODY or as an escaped DLE.
    always_comb begin
        w_store = 1'b0;
        if (w_strobe) begin
            if (r_state == StBody) begin
                w_store = (w_byte != DLE);
            end else if (r_state == StEsc) begin
                w_store = (w_byte == DLE);
            end
        end
    end

    assign w_full = (r_count == CW'(BUF_BYTES));

    always_ff @(posedge i_sb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StHunt;
            r_crc         <= CRC_SEED;
            r_count       <= '0;
            for (int i = 0; i < int'(BUF_BYTES); i++) r_buf[i] <= '0;
            o_payload     <= '0;
            o_payload_len <= '0;
            o_crc_ok      <= 1'b0;
            o_frame_valid <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            o_frame_error <= 1'b0;
            if (w_stop_fail) begin
                if (r_state != StHunt) begin
                    o_frame_error <= 1'b1;
                    r_state       <= StHunt;
                end
            end else if (w_strobe) begin
                unique case (r_state)
                    StHunt: begin
                        if (w_byte == DLE) r_state <= StSof;
                    end
                    StSof: begin
                        if (w_byte == STX) begin
                            r_state <= StBody;
                            r_crc   <= crc16_byte(CRC_SEED, STX);
                            r_count <= '0;
                        end else if (w_byte != DLE) begin
                            r_state <= StHunt;
                        end
                    end
                    StBody: begin
                        if (w_byte == DLE) r_state <= StEsc;
                    end
                    StEsc: begin
                        if (w_byte == ETX) begin
                            r_state <= StHunt;
                            if (r_count < CW'(2)) begin
                                o_frame_error <= 1'b1;
                            end else begin
                                o_frame_valid <= 1'b1;
                                o_payload_len <= LW'(r_count - CW'(2));
                                o_crc_ok      <= (r_crc == 16'h0000);
                                for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
                                    o_payload[8*i +: 8] <= r_buf[i];
                                end
                            end
                        end else if (w_byte != DLE) begin
                            o_frame_error <= 1'b1;
                            r_state       <= StHunt;
                        end
                    end
                    default: r_state <= StHunt;
                endcase

                if (w_store) begin
                    if (w_full) begin
                        o_frame_error <= 1'b1;
                        r_state       <= StHunt;
                    end else begin
                        r_buf[r_count] <= w_byte;
                        r_crc          <= crc16_byte(r_crc, w_byte);
                        r_count        <= r_count + CW'(1);
                        r_state        <= StBody;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_rx_framer.sv
// Directed self-checking bench for sb_rx_framer: good, stuffed, corrupt, aborted and reset frames.
module tb_sb_rx_framer;

    localparam int MAXP = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            sbrx  = 1'b1;
    logic [8*MAXP-1:0] payload;
    logic [3:0]      plen;
    logic            crc_ok;
    logic            fvalid;
    logic            ferr;
    logic            serr;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_serr   = 0;
    int n_both   = 0;
    int cyc      = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;
    int nsym     = 0;

    logic [63:0] cap_payload = '0;
    logic [3:0]  cap_len     = '0;
    logic        cap_crc     = 1'b0;

    always #5 clk = ~clk;

    sb_rx_framer #(
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .i_sb_clk      (clk),
        .i_rst_n       (rst_n),
        .i_sbrx        (sbrx),
        .o_payload     (payload),
        .o_payload_len (plen),
        .o_crc_ok      (crc_ok),
        .o_frame_valid (fvalid),
        .o_frame_error (ferr),
        .o_sym_error   (serr)
    );

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fvalid) begin
                n_valid++;
                prev_vcyc   = last_vcyc;
                last_vcyc   = cyc;
                cap_payload = payload;
                cap_len     = plen;
                cap_crc     = crc_ok;
            end
            if (ferr) n_ferr++;
            if (serr) n_serr++;
            if (ferr && serr) n_both++;
        end
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = c << 1;
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sbrx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        nsym++;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_sym(d, 1'b1);
    endtask

    task automatic send_stuffed(input logic [7:0] d);
        send_byte(d);
        if (d == 8'hFE) send_byte(8'hFE);
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // Bytes are packed LSB-first; CRC is computed over STX plus crc_body, then appended high/low.
    task automatic send_frame(input logic [63:0] body, input int n, input logic [63:0] crc_body);
        logic [15:0] c;
        c = crc_step(16'hFFFF, 8'h05);
        for (int i = 0; i < n; i++) c = crc_step(c, crc_body[8*i +: 8]);
        send_byte(8'hFE);
        send_byte(8'h05);
        for (int i = 0; i < n; i++) send_stuffed(body[8*i +: 8]);
        send_stuffed(c[15:8]);
        send_stuffed(c[7:0]);
        send_byte(8'hFE);
        send_byte(8'h40);
    endtask

    initial begin
        int v0, f0, s0, b0, n1, n2;

        // Reset state
        rst_n = 1'b0;
        sbrx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_payload", 64'(payload), 64'h0);
        chk("rst_flags", 64'({plen, crc_ok, fvalid, ferr, serr}), 64'h0);
        rst_n = 1'b1;
        idle(4);

        // Good frame 12 34 56
        v0 = n_valid; f0 = n_ferr; s0 = n_serr;
        send_frame(64'h563412, 3, 64'h563412);
        idle(4);
        chk("good_valid", 64'(n_valid - v0), 64'd1);
        chk("good_len", 64'(cap_len), 64'd3);
        chk("good_payload", 64'(cap_payload[23:0]), 64'h563412);
        chk("good_crc", 64'(cap_crc), 64'd1);
        chk("good_noerr", 64'((n_ferr - f0) + (n_serr - s0)), 64'd0);

        // DLE stuffing: 12 FE 34
        v0 = n_valid;
        send_frame(64'h34FE12, 3, 64'h34FE12);
        idle(4);
        chk("stuff_valid", 64'(n_valid - v0), 64'd1);
        chk("stuff_len", 64'(cap_len), 64'd3);
        chk("stuff_byte1", 64'(cap_payload[15:8]), 64'hFE);
        chk("stuff_crc", 64'(cap_crc), 64'd1);

        // Corrupted payload: 34 -> 35, CRC of the original
        v0 = n_valid;
        send_frame(64'h563512, 3, 64'h563412);
        idle(4);
        chk("corrupt_valid", 64'(n_valid - v0), 64'd1);
        chk("corrupt_crc", 64'(cap_crc), 64'd0);
        chk("corrupt_payload", 64'(cap_payload[23:0]), 64'h563512);

        // Stop-bit error mid-payload, then line held low
        v0 = n_valid; f0 = n_ferr; s0 = n_serr; b0 = n_both;
        send_byte(8'hFE);
        send_byte(8'h05);
        send_byte(8'h12);
        send_sym(8'h34, 1'b0);
        repeat (20) send_bit(1'b0);
        chk("stop_sym_err", 64'(n_serr - s0), 64'd1);
        chk("stop_frame_err", 64'(n_ferr - f0), 64'd1);
        chk("stop_same_cycle", 64'(n_both - b0), 64'd1);
        idle(5);
        chk("stop_after_high", 64'(n_serr - s0), 64'd1);
        chk("stop_no_valid", 64'(n_valid - v0), 64'd0);
        chk("stop_hold_payload", 64'(payload[23:0]), 64'h563512);
        chk("stop_hold_len_crc", 64'({plen, crc_ok}), 64'({4'd3, 1'b0}));

        // Short frame: one stored byte
        f0 = n_ferr; v0 = n_valid;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hFE); send_byte(8'h40);
        idle(3);
        chk("short_err", 64'(n_ferr - f0), 64'd1);
        chk("short_no_valid", 64'(n_valid - v0), 64'd0);

        // Bad escape: DLE followed by 33
        f0 = n_ferr;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h12); send_byte(8'hFE); send_byte(8'h33);
        idle(3);
        chk("esc_err", 64'(n_ferr - f0), 64'd1);

        // Maximum payload: 8 bytes
        v0 = n_valid; f0 = n_ferr;
        send_frame(64'h8877665544332211, 8, 64'h8877665544332211);
        idle(4);
        chk("max_valid", 64'(n_valid - v0), 64'd1);
        chk("max_len", 64'(cap_len), 64'd8);
        chk("max_payload", cap_payload, 64'h8877665544332211);
        chk("max_crc_noerr", 64'({cap_crc, 4'(n_ferr - f0)}), 64'({1'b1, 4'd0}));

        // Overflow: 11 body bytes
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'hFE); send_byte(8'h05);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        idle(3);
        chk("ovf_before_11th", 64'(n_ferr - f0), 64'd0);
        send_byte(8'h0B);
        idle(3);
        chk("ovf_on_11th", 64'(n_ferr - f0), 64'd1);
        send_byte(8'hFE); send_byte(8'h40);
        idle(3);
        chk("ovf_no_valid", 64'(n_valid - v0), 64'd0);
        chk("ovf_single_err", 64'(n_ferr - f0), 64'd1);
        send_frame(64'hB2A1, 2, 64'hB2A1);
        idle(4);
        chk("ovf_next_valid", 64'(n_valid - v0), 64'd1);
        chk("ovf_next_len", 64'(cap_len), 64'd2);
        chk("ovf_next_payload", 64'(cap_payload[15:0]), 64'hB2A1);
        chk("ovf_next_crc", 64'(cap_crc), 64'd1);

        // Asynchronous reset mid-frame
        v0 = n_valid; f0 = n_ferr; s0 = n_serr;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
        sbrx = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_payload", 64'(payload), 64'h0);
        chk("mid_rst_flags", 64'({plen, crc_ok, fvalid, ferr, serr}), 64'h0);
        sbrx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);
        chk("mid_rst_no_pulse", 64'((n_valid - v0) + (n_ferr - f0) + (n_serr - s0)), 64'd0);

        // Back-to-back zero-gap frames
        v0 = n_valid;
        send_frame(64'h563412, 3, 64'h563412);
        n1 = nsym;
        send_frame(64'h563412, 3, 64'h563412);
        n2 = nsym;
        idle(4);
        chk("b2b_valid", 64'(n_valid - v0), 64'd2);
        chk("b2b_gap", 64'(last_vcyc - prev_vcyc), 64'(10 * (n2 - n1)));
        chk("b2b_len_crc", 64'({cap_len, cap_crc}), 64'({4'd3, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
